// File: rtl/dcntr8.sv
// 8-bit loadable down-counter with wrap/stop-at-zero modes and a three-state control FSM.
// The decrement uses two 4-bit borrow-lookahead groups; the low-group borrow feeds the high group.
module dcntr8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] d_in,
    input  logic       en,
    input  logic       mode,
    output logic [7:0] q,
    output logic       bo,
    output logic       done,
    output logic       zero
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state;

    logic [7:0] prop;
    logic [7:0] brw;
    logic [7:0] q_dec;
    logic       lo_bo;

    assign zero = (q == 8'h00);

    // Each borrow is the AND of the propagates below it within its group,
    // so no bit waits on the previous bit's borrow.
    always_comb begin
        prop   = ~q;
        lo_bo  = &prop[3:0];
        brw    = '0;
        brw[0] = 1'b1;
        brw[1] = prop[0];
        brw[2] = &prop[1:0];
        brw[3] = &prop[2:0];
        brw[4] = lo_bo;
        brw[5] = lo_bo & prop[4];
        brw[6] = lo_bo & (&prop[5:4]);
        brw[7] = lo_bo & (&prop[6:4]);
        q_dec  = q ^ brw;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            q     <= '0;
            bo    <= 1'b0;
            done  <= 1'b0;
        end else begin
            bo <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        q     <= d_in;
                        state <= RUN;
                    end else if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        q <= d_in;
                    end else if (en) begin
                        if (!zero) begin
                            q <= q_dec;
                        end else if (!mode) begin
                            q  <= q_dec;
                            bo <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (load) begin
                        q     <= d_in;
                        state <= RUN;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcntr8.sv
// Directed self-checking bench for dcntr8: load/count, wrap, stop, collision,
// asynchronous reset and a full 256-step wrap sweep.
module tb_dcntr8;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] d_in;
    logic       en;
    logic       mode;
    logic [7:0] q;
    logic       bo;
    logic       done;
    logic       zero;

    int vectors;
    int miscompares;

    dcntr8 dut (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .d_in (d_in),
        .en   (en),
        .mode (mode),
        .q    (q),
        .bo   (bo),
        .done (done),
        .zero (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after each rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq, input logic ebo, input logic edone);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".bo"}, {7'd0, bo}, {7'd0, ebo});
        chk({tag, ".done"}, {7'd0, done}, {7'd0, edone});
        chk({tag, ".zero"}, {7'd0, zero}, {7'd0, (eq == 8'h00)});
    endtask

    initial begin
        logic [7:0] e;
        int         bo_count;
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1; load = 1'b0; d_in = 8'h00; en = 1'b0; mode = 1'b0;

        #3;
        chk_all("reset", 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b0;

        load = 1'b1; d_in = 8'h12;
        tick(); chk_all("ld12", 8'h12, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        tick(); chk_all("cnt11", 8'h11, 1'b0, 1'b0);
        tick(); chk_all("cnt10", 8'h10, 1'b0, 1'b0);
        tick(); chk_all("cnt0f", 8'h0F, 1'b0, 1'b0);
        en = 1'b0;
        tick(); chk_all("hold0f", 8'h0F, 1'b0, 1'b0);

        load = 1'b1; d_in = 8'h01; mode = 1'b0;
        tick(); chk_all("ld01", 8'h01, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        tick(); chk_all("wrap00", 8'h00, 1'b0, 1'b0);
        tick(); chk_all("wrapff", 8'hFF, 1'b1, 1'b0);
        en = 1'b0;
        tick(); chk_all("wrapholdff", 8'hFF, 1'b0, 1'b0);

        load = 1'b1; d_in = 8'h02; mode = 1'b1;
        tick(); chk_all("ld02", 8'h02, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        tick(); chk_all("stop01", 8'h01, 1'b0, 1'b0);
        tick(); chk_all("stop00", 8'h00, 1'b0, 1'b0);
        tick(); chk_all("stopdone", 8'h00, 1'b0, 1'b1);
        tick(); chk_all("stopdone2", 8'h00, 1'b0, 1'b1);
        mode = 1'b0;
        tick(); chk_all("doneign", 8'h00, 1'b0, 1'b1);

        load = 1'b1; d_in = 8'h00; en = 1'b0;
        tick(); chk_all("ld00", 8'h00, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        tick(); chk_all("ld00wrap", 8'hFF, 1'b1, 1'b0);

        load = 1'b1; d_in = 8'h00; en = 1'b0;
        tick(); chk_all("ld00b", 8'h00, 1'b0, 1'b0);
        load = 1'b1; d_in = 8'hA5; en = 1'b1;
        tick(); chk_all("collide", 8'hA5, 1'b0, 1'b0);
        load = 1'b0;
        tick(); chk_all("collrun", 8'hA4, 1'b0, 1'b0);

        load = 1'b1; d_in = 8'h81; en = 1'b0;
        tick(); chk_all("ld81", 8'h81, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        tick(); chk_all("cnt80", 8'h80, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1 chk_all("async", 8'h00, 1'b0, 1'b0);
        load = 1'b1; d_in = 8'h55; en = 1'b1;
        tick(); chk_all("rstign", 8'h00, 1'b0, 1'b0);
        #2 reset = 1'b0; load = 1'b0; en = 1'b0; mode = 1'b0;
        tick(); chk_all("idlehold", 8'h00, 1'b0, 1'b0);
        en = 1'b1;
        tick(); chk_all("idleen", 8'h00, 1'b0, 1'b0);
        tick(); chk_all("idlerun", 8'hFF, 1'b1, 1'b0);

        load = 1'b1; d_in = 8'h01; en = 1'b0; mode = 1'b1;
        tick(); chk_all("ld01b", 8'h01, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        tick(); chk_all("stop00b", 8'h00, 1'b0, 1'b0);
        tick(); chk_all("doneb", 8'h00, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1 chk_all("asyncdone", 8'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b0;

        load = 1'b1; d_in = 8'hFF; en = 1'b0; mode = 1'b0;
        tick(); chk_all("ldff", 8'hFF, 1'b0, 1'b0);
        load = 1'b0; en = 1'b1;
        bo_count = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            e = 8'hFE - 8'(i);
            if (bo) bo_count++;
            chk("sweep.q", q, e);
            chk("sweep.bo", {7'd0, bo}, {7'd0, (i == 255)});
        end
        chk("sweep.bocount", 8'(bo_count), 8'd1);
        en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
